lift53_row_engine: RTL and testbench

- In-place 5/3 integer lifting engine for one image row of N_SAMPLES signed samples, stored as split even/odd banks.
- Parametrised successor of the fixed 26-bit / 7-bit-address even/odd pixel RAM: width and row length are generic, and it adds an internal predict/update sequencer with start/done handshake, forward and inverse modes, and a host load/readback port.
- Sits between the row-buffer loader and the column pass of the DWT datapath.

---
 rtl/lift53_row_engine_pkg.sv | 36 +++
 rtl/lift53_row_engine_if.sv | 28 ++
 rtl/lift53_row_engine_bank.sv | 37 +++
 rtl/lift53_row_engine.sv | 144 ++++++++++++++
 tb/tb_lift53_row_engine.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lift53_row_engine_pkg.sv
// Shared types and arithmetic helpers for the 5/3 row lifting engine.
// Build option: LIFT53_SATURATE_EN clamps lifting results instead of wrapping.
package lift53_row_engine_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRED,
        UPD,
        FIN
    } state_t;

    localparam logic FWD = 1'b1;
    localparam logic INV = 1'b0;

    // Reduce a wide lifting result to w bits, returned sign-extended to 64 bits.
    // The caller keeps the low w bits of the returned value.
    function automatic logic signed [63:0] lift_clip(input logic signed [63:0] s,
                                                     input int unsigned        w);
`ifdef LIFT53_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return s;
        end
`else
        return (s <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/lift53_row_engine_if.sv
// Host-side bus of the row lifting engine: load/readback port plus start/done handshake.
interface lift53_row_engine_if #(
    parameter int unsigned W         = 26,
    parameter int unsigned N_SAMPLES = 256
);
    localparam int unsigned AW = $clog2(N_SAMPLES);

    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_din;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_dout;
    logic          start;
    logic          fwd_inv;
    logic          busy;
    logic          done;

    modport master (
        output ld_we, ld_addr, ld_din, rd_addr, start, fwd_inv,
        input  rd_dout, busy, done
    );

    modport slave (
        input  ld_we, ld_addr, ld_din, rd_addr, start, fwd_inv,
        output rd_dout, busy, done
    );

endinterface

// File: rtl/lift53_row_engine_bank.sv
// One half-row sample bank: three combinational reads (engine centre, engine
// neighbour, host) and a single write port shared by engine and host.
module lift53_bank #(
    parameter int unsigned W   = 26,
    parameter int unsigned H   = 128,
    parameter int unsigned AWB = $clog2(H)
) (
    input  logic           clk,
    input  logic [AWB-1:0] ca_i,
    input  logic [AWB-1:0] na_i,
    output logic [W-1:0]   cd_o,
    output logic [W-1:0]   nd_o,
    input  logic [AWB-1:0] ha_i,
    output logic [W-1:0]   hd_o,
    input  logic           eng_we_i,
    input  logic [W-1:0]   eng_wd_i,
    input  logic           host_we_i,
    input  logic [AWB-1:0] host_wa_i,
    input  logic [W-1:0]   host_wd_i
);

    logic [W-1:0] mem_q [H];

    assign cd_o = mem_q[ca_i];
    assign nd_o = mem_q[na_i];
    assign hd_o = mem_q[ha_i];

    // Write port: engine writes back at its centre index, otherwise the host may write.
    always_ff @(posedge clk) begin
        if (eng_we_i) begin
            mem_q[ca_i] <= eng_wd_i;
        end else if (host_we_i) begin
            mem_q[host_wa_i] <= host_wd_i;
        end
    end

endmodule

// File: rtl/lift53_row_engine.sv
// In-place 5/3 integer lifting over one row held as even/odd banks, with a
// predict/update sequencer, forward/inverse modes and a host load/read port.
// Build option: LIFT53_SATURATE_EN clamps each lifting result to W bits.
module lift53_row_engine
    import lift53_row_engine_pkg::*;
#(
    parameter int unsigned W         = 26,
    parameter int unsigned N_SAMPLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    lift53_row_engine_if.slave  bus
);

    localparam int unsigned AW = $clog2(N_SAMPLES);
    localparam int unsigned H  = N_SAMPLES / 2;
    localparam int unsigned HW = AW - 1;
    localparam logic signed [W+1:0] TWO = (W + 2)'(2);

    state_t        state_q;
    logic [HW-1:0] idx_q;
    logic          mode_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  rd_dout_q;

    logic [HW-1:0] e_nidx_d;
    logic [HW-1:0] o_nidx_d;
    logic [W-1:0]  e_c, e_n, e_h;
    logic [W-1:0]  o_c, o_p, o_h;
    logic          host_we_d;

    logic signed [W+1:0] e_c_x, e_n_x, o_c_x, o_p_x;
    logic signed [W+1:0] pred_half, pred_sum, upd_q4, upd_sum;
    logic [W-1:0]        pred_w, upd_w;

    // Symmetric extension at the row ends.
    assign e_nidx_d = (idx_q == HW'(H - 1)) ? idx_q : idx_q + HW'(1);
    assign o_nidx_d = (idx_q == '0) ? '0 : idx_q - HW'(1);

    assign host_we_d = bus.ld_we && (state_q == IDLE);

    lift53_bank #(.W(W), .H(H), .AWB(HW)) u_even (
        .clk       (clk),
        .ca_i      (idx_q),
        .na_i      (e_nidx_d),
        .cd_o      (e_c),
        .nd_o      (e_n),
        .ha_i      (bus.rd_addr[AW-1:1]),
        .hd_o      (e_h),
        .eng_we_i  (state_q == UPD),
        .eng_wd_i  (upd_w),
        .host_we_i (host_we_d && !bus.ld_addr[0]),
        .host_wa_i (bus.ld_addr[AW-1:1]),
        .host_wd_i (bus.ld_din)
    );

    lift53_bank #(.W(W), .H(H), .AWB(HW)) u_odd (
        .clk       (clk),
        .ca_i      (idx_q),
        .na_i      (o_nidx_d),
        .cd_o      (o_c),
        .nd_o      (o_p),
        .ha_i      (bus.rd_addr[AW-1:1]),
        .hd_o      (o_h),
        .eng_we_i  (state_q == PRED),
        .eng_wd_i  (pred_w),
        .host_we_i (host_we_d && bus.ld_addr[0]),
        .host_wa_i (bus.ld_addr[AW-1:1]),
        .host_wd_i (bus.ld_din)
    );

    assign e_c_x = {{2{e_c[W-1]}}, e_c};
    assign e_n_x = {{2{e_n[W-1]}}, e_n};
    assign o_c_x = {{2{o_c[W-1]}}, o_c};
    assign o_p_x = {{2{o_p[W-1]}}, o_p};

    assign pred_half = (e_c_x + e_n_x) >>> 1;
    assign pred_sum  = (mode_q == FWD) ? o_c_x - pred_half : o_c_x + pred_half;
    assign upd_q4    = (o_p_x + o_c_x + TWO) >>> 2;
    assign upd_sum   = (mode_q == FWD) ? e_c_x + upd_q4 : e_c_x - upd_q4;

    assign pred_w = W'(lift_clip({{(62 - W){pred_sum[W+1]}}, pred_sum}, W));
    assign upd_w  = W'(lift_clip({{(62 - W){upd_sum[W+1]}}, upd_sum}, W));

    // Sequencer: first phase, second phase, one-cycle FIN with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= FWD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q  <= bus.fwd_inv;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.fwd_inv == FWD) ? PRED : UPD;
                    end
                end
                PRED, UPD: begin
                    if (idx_q == HW'(H - 1)) begin
                        idx_q <= '0;
                        // Forward runs PRED then UPD; inverse runs UPD then PRED.
                        if ((state_q == PRED) == (mode_q == FWD)) begin
                            state_q <= (state_q == PRED) ? UPD : PRED;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + HW'(1);
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Registered host readback from the bank selected by the address LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dout_q <= '0;
        end else begin
            rd_dout_q <= bus.rd_addr[0] ? o_h : e_h;
        end
    end

    assign bus.rd_dout = rd_dout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_lift53_row_engine.sv
// Directed bench for the 5/3 row lifting engine: table of row/probe vectors
// plus hand-written sequences for handshake, reset and round-trip cases.
module tb_lift53_row_engine;

    localparam int W     = 26;
    localparam int N     = 256;
    localparam int H     = N / 2;
    localparam int AW    = 8;
    localparam int LAT   = 2 * H + 1;
    localparam int LIMIT = 600;

`ifdef LIFT53_SATURATE_EN
    localparam logic [W-1:0] SAT_EXP = 26'h2000000;
`else
    localparam logic [W-1:0] SAT_EXP = 26'h0000001;
`endif

    logic clk;
    logic rst_n;

    lift53_row_engine_if #(.W(W), .N_SAMPLES(N)) bus ();

    lift53_row_engine #(.W(W), .N_SAMPLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    base;
        int    step;
        int    addr;
        int    exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    logic [W-1:0] row  [N];
    logic [W-1:0] orig [N];

    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic load_row();
        for (int n = 0; n < N; n++) begin
            bus.ld_we   = 1'b1;
            bus.ld_addr = AW'(n);
            bus.ld_din  = row[n];
            tick();
        end
        bus.ld_we = 1'b0;
    endtask

    task automatic read_one(input int a, output logic [W-1:0] v);
        bus.rd_addr = AW'(a);
        tick();
        v = bus.rd_dout;
    endtask

    // Start a transform and count cycles to done. dist_at pulses start plus a
    // host write to addr 0 at that cycle; rst_at pulls reset at that cycle.
    task automatic run(input logic fwd, input int dist_at, input int rst_at,
                       input logic co_we, input int co_addr, input logic [W-1:0] co_din,
                       output int cyc);
        bus.start   = 1'b1;
        bus.fwd_inv = fwd;
        bus.ld_we   = co_we;
        bus.ld_addr = AW'(co_addr);
        bus.ld_din  = co_din;
        tick();
        bus.start = 1'b0;
        bus.ld_we = 1'b0;
        cyc = 1;
        check("busy_c1", W'(bus.busy), W'(1));
        while (cyc <= LIMIT) begin
            if (bus.done) break;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", W'(bus.busy), W'(0));
                check("rst_done", W'(bus.done), W'(0));
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                cyc = 0;
                return;
            end
            if (cyc == dist_at) begin
                bus.start   = 1'b1;
                bus.fwd_inv = ~fwd;
                bus.ld_we   = 1'b1;
                bus.ld_addr = '0;
                bus.ld_din  = 26'h3FF;
            end
            tick();
            bus.start = 1'b0;
            bus.ld_we = 1'b0;
            cyc++;
        end
        if (bus.done) begin
            check("busy_at_done", W'(bus.busy), W'(1));
            tick();
            check("busy_after", W'(bus.busy), W'(0));
            check("done_pulse", W'(bus.done), W'(0));
        end
    endtask

    initial begin
        int           cyc;
        int           v;
        int           bad;
        int           first_bad;
        logic [W-1:0] rv;

        vecs[0]  = '{"c_e0",    100,  0,   0,   100};
        vecs[1]  = '{"c_o0",    100,  0,   1,     0};
        vecs[2]  = '{"c_e127",  100,  0, 254,   100};
        vecs[3]  = '{"c_o127",  100,  0, 255,     0};
        vecs[4]  = '{"r_o0",      0,  1,   1,     0};
        vecs[5]  = '{"r_o126",    0,  1, 253,     0};
        vecs[6]  = '{"r_o127",    0,  1, 255,     1};
        vecs[7]  = '{"r_e127",    0,  1, 254,   254};
        vecs[8]  = '{"r_e50",     0,  1, 100,   100};
        vecs[9]  = '{"r_e0",      0,  1,   0,     0};
        vecs[10] = '{"n_o127", -1000, -3, 255,    -3};
        vecs[11] = '{"n_e127", -1000, -3, 254, -1763};
        vecs[12] = '{"n_e10",  -1000, -3,  20, -1060};
        vecs[13] = '{"n_o5",   -1000, -3,  11,     0};
        vecs[14] = '{"s8_e127",   0,  8, 254,  2034};
        vecs[15] = '{"s8_o127",   0,  8, 255,     8};

        rst_n       = 1'b0;
        bus.ld_we   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_din  = '0;
        bus.rd_addr = '0;
        bus.start   = 1'b0;
        bus.fwd_inv = 1'b1;
        repeat (2) tick();
        check("reset_busy", W'(bus.busy), W'(0));
        check("reset_done", W'(bus.done), W'(0));
        check("reset_rd_dout", bus.rd_dout, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Linear rows, forward transform, probed readback
        for (int i = 0; i < NV; i++) begin
            if (i == 0 || vecs[i].base != vecs[i-1].base || vecs[i].step != vecs[i-1].step) begin
                for (int n = 0; n < N; n++) begin
                    v = vecs[i].base + vecs[i].step * n;
                    row[n] = v[W-1:0];
                end
                load_row();
                run(1'b1, 0, 0, 1'b0, 0, '0, cyc);
                check({vecs[i].name, "_lat"}, W'(cyc), W'(LAT));
            end
            read_one(vecs[i].addr, rv);
            v = vecs[i].exp;
            check(vecs[i].name, rv, v[W-1:0]);
        end

        // Host write to O[0] in the same cycle as start is seen by the transform
        for (int n = 0; n < N; n++) row[n] = 26'd100;
        load_row();
        run(1'b1, 0, 0, 1'b1, 1, 26'd500, cyc);
        check("co_lat", W'(cyc), W'(LAT));
        read_one(1, rv);
        check("co_o0", rv, 26'd400);
        read_one(0, rv);
        check("co_e0", rv, 26'd300);
        read_one(2, rv);
        check("co_e1", rv, 26'd200);

        // Start and host write while busy are both ignored
        load_row();
        run(1'b1, 5, 0, 1'b0, 0, '0, cyc);
        check("dist_lat", W'(cyc), W'(LAT));
        read_one(0, rv);
        check("dist_e0", rv, 26'd100);
        read_one(1, rv);
        check("dist_o0", rv, 26'd0);

        // Reset mid-run, then a fresh run completes with normal latency
        load_row();
        run(1'b1, 0, 40, 1'b0, 0, '0, cyc);
        run(1'b1, 0, 0, 1'b0, 0, '0, cyc);
        check("post_rst_lat", W'(cyc), W'(LAT));

        // Predict overflow: wrap gives 1, saturation clamps to -2^25
        for (int n = 0; n < N; n++) row[n] = (n % 2 == 0) ? 26'h1FFFFFF : 26'h2000000;
        load_row();
        run(1'b1, 0, 0, 1'b0, 0, '0, cyc);
        check("ovf_lat", W'(cyc), W'(LAT));
        read_one(1, rv);
        check("ovf_o0", rv, SAT_EXP);
        read_one(201, rv);
        check("ovf_o100", rv, SAT_EXP);

        // Random row: forward then inverse must reconstruct exactly
        for (int n = 0; n < N; n++) begin
            v = int'($urandom_range(32'd2097151, 32'd0)) - 1048576;
            row[n]  = v[W-1:0];
            orig[n] = v[W-1:0];
        end
        load_row();
        run(1'b1, 0, 0, 1'b0, 0, '0, cyc);
        check("rt_fwd_lat", W'(cyc), W'(LAT));
        run(1'b0, 0, 0, 1'b0, 0, '0, cyc);
        check("rt_inv_lat", W'(cyc), W'(LAT));
        bad = 0;
        first_bad = -1;
        for (int n = 0; n < N; n++) begin
            read_one(n, rv);
            if (rv !== orig[n]) begin
                bad++;
                if (first_bad < 0) first_bad = n;
            end
        end
        if (first_bad >= 0) $display("first round-trip difference at sample %0d", first_bad);
        check("rt_mismatch_count", W'(bad), W'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
